reshape_stream: RTL and testbench

// - Streaming successor to the combinational Cvt2DTo1D/Cvt1DTo2D/Reshape converters: a gearbox that reshapes
//   CNT_I x NBIT_I element beats into CNT_O x NBIT_O element beats across clock cycles, with any IW:OW ratio.
// - Sits between datapath stages of different beat widths (e.g. 4x8b memory words -> 2x8b or 1x12b PE lanes).
// - Valid/ready on both sides, packet termination via last, zero-padded partial final beat with element count.

---
 rtl/reshape_pkg.sv | 15 +
 rtl/Cvt1DTo2D.sv | 16 +
 rtl/Cvt2DTo1D.sv | 17 +
 rtl/reshape_stream.sv | 99 +++++++++
 tb/tb_reshape_stream.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reshape_pkg.sv
// Width helpers shared by the stream gearbox and the combinational
// 2D <-> 1D element converters.
package reshape_pkg;

  // Flat bit width of a vector of cnt elements of nbit bits each.
  function automatic int flat_w(input int nbit, input int cnt);
    return nbit * cnt;
  endfunction

  // Integer ceiling division, used for element counts of partial beats.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/Cvt1DTo2D.sv
// Splits a flat word back into elements; MSBs become element 0.
module Cvt1DTo2D
  import reshape_pkg::*;
#(
  parameter int NBIT = 8,
  parameter int CNT  = 2
) (
  input  logic [flat_w(NBIT,CNT)-1:0] i_data,
  output logic [NBIT-1:0]             o_data [0:CNT-1]
);

  for (genvar j = 0; j < CNT; j++) begin : g_elem
    assign o_data[j] = i_data[NBIT*(CNT-j)-1 -: NBIT];
  end

endmodule

// File: rtl/Cvt2DTo1D.sv
// Flattens an element array into one word; element 0 lands in the MSBs so
// that reading the word MSB-first follows stream order.
module Cvt2DTo1D
  import reshape_pkg::*;
#(
  parameter int NBIT = 8,
  parameter int CNT  = 4
) (
  input  logic [NBIT-1:0]             i_data [0:CNT-1],
  output logic [flat_w(NBIT,CNT)-1:0] o_data
);

  for (genvar j = 0; j < CNT; j++) begin : g_elem
    assign o_data[NBIT*(CNT-j)-1 -: NBIT] = i_data[j];
  end

endmodule

// File: rtl/reshape_stream.sv
// Streaming gearbox: re-chunks CNT_I x NBIT_I input beats into
// CNT_O x NBIT_O output beats through an MSB-aligned bit buffer. The last
// beat of a packet is zero-padded and reports how many elements it carries.
module reshape_stream
  import reshape_pkg::*;
#(
  parameter int  NBIT_I = 8,
  parameter int  CNT_I  = 4,
  parameter int  NBIT_O = 8,
  parameter int  CNT_O  = 2,
  localparam int IW     = flat_w(NBIT_I, CNT_I),
  localparam int OW     = flat_w(NBIT_O, CNT_O),
  localparam int BW     = IW + OW,
  localparam int CW     = $clog2(BW + 1),
  localparam int KW     = $clog2(CNT_O + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [NBIT_I-1:0] i_data [0:CNT_I-1],
  input  logic              i_last,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [NBIT_O-1:0] o_data [0:CNT_O-1],
  output logic              o_last,
  output logic [KW-1:0]     o_cnt
);

  if (NBIT_I < 1 || CNT_I < 1 || NBIT_O < 1 || CNT_O < 1) begin : g_bad_param
    $error("reshape_stream: NBIT_I, CNT_I, NBIT_O and CNT_O must all be >= 1");
  end

  localparam logic [CW-1:0] OW_C = CW'(OW);
  localparam logic [CW-1:0] IW_C = CW'(IW);

  logic [IW-1:0] w_i_flat;
  logic [OW-1:0] w_o_flat;
  logic [OW-1:0] w_mask;
  logic [BW-1:0] r_buf, w_buf_pop, w_ins, w_buf_nxt;
  logic [CW-1:0] r_cnt, w_cnt_pop, w_cnt_nxt;
  logic          r_pend, w_pend_nxt;
  logic          w_pop, w_push;

  Cvt2DTo1D #(.NBIT(NBIT_I), .CNT(CNT_I)) u_flatten (
    .i_data (i_data),
    .o_data (w_i_flat)
  );

  Cvt1DTo2D #(.NBIT(NBIT_O), .CNT(CNT_O)) u_unflatten (
    .i_data (w_o_flat),
    .o_data (o_data)
  );

  // Handshake, output masking and element count, then pop-before-push next state.
  always_comb begin
    // NOTE: every signal gets a value on every path of a combinational block;
    // a missing branch would infer a latch.
    i_ready    = !rst && !r_pend && (r_cnt <= OW_C);
    o_valid    = (r_cnt >= OW_C) || (r_pend && (r_cnt != '0));
    o_last     = o_valid && r_pend && (r_cnt <= OW_C);
    w_mask     = (r_cnt >= OW_C) ? '1 : ~({OW{1'b1}} >> r_cnt);
    w_o_flat   = r_buf[BW-1 -: OW] & w_mask;
    o_cnt      = '0;
    if (o_last)       o_cnt = KW'(ceil_div(32'(r_cnt), NBIT_O));
    else if (o_valid) o_cnt = KW'(CNT_O);

    w_pop      = o_valid && o_ready;
    w_push     = i_valid && i_ready;
    // Bits below cnt are always zero, so the new beat can simply be OR-ed in
    // right behind the bits that survive this cycle's pop.
    w_buf_pop  = w_pop ? (r_buf << OW) : r_buf;
    w_cnt_pop  = w_pop ? ((r_cnt >= OW_C) ? (r_cnt - OW_C) : '0) : r_cnt;
    w_ins      = {w_i_flat, {OW{1'b0}}} >> w_cnt_pop;
    w_buf_nxt  = w_push ? (w_buf_pop | w_ins) : w_buf_pop;
    w_cnt_nxt  = w_push ? (w_cnt_pop + IW_C) : w_cnt_pop;
    w_pend_nxt = r_pend;
    if (w_pop && o_last)  w_pend_nxt = 1'b0;
    if (w_push && i_last) w_pend_nxt = 1'b1;
  end

  // Buffer, fill level and packet-tail flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the buffer is reset as well, not just cnt: the zero-fill below
      // cnt is what makes the OR-insert above correct.
      r_buf  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge state, independent of statement order.
      r_buf  <= w_buf_nxt;
      r_cnt  <= w_cnt_nxt;
      r_pend <= w_pend_nxt;
    end
  end

endmodule

// File: tb/tb_reshape_stream.sv
// Self-checking bench for reshape_stream: three gearbox shapes (4x8->2x8,
// 1x8->3x8, 3x4->1x8) with directed scenarios and a randomized bit-stream
// reference model.
module tb_reshape_stream;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } in_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cnt;
  } exp_t;

  localparam int IWA [3]  = '{32, 8, 12};
  localparam int OWA [3]  = '{16, 24, 8};
  localparam int NBOA [3] = '{8, 8, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  in_t  in_q  [$];
  exp_t exp_q [$];

  // Instance 0: 4x8 -> 2x8
  logic        iv0 = 0, il0 = 0, ordy0 = 0, ir0, ov0, ol0;
  logic [31:0] fin0 = '0;
  logic [15:0] fout0;
  logic [1:0]  oc0;
  logic [7:0]  d0_in [0:3];
  logic [7:0]  d0_out [0:1];
  // Instance 1: 1x8 -> 3x8
  logic        iv1 = 0, il1 = 0, ordy1 = 0, ir1, ov1, ol1;
  logic [7:0]  fin1 = '0;
  logic [23:0] fout1;
  logic [1:0]  oc1;
  logic [7:0]  d1_in [0:0];
  logic [7:0]  d1_out [0:2];
  // Instance 2: 3x4 -> 1x8
  logic        iv2 = 0, il2 = 0, ordy2 = 0, ir2, ov2, ol2;
  logic [11:0] fin2 = '0;
  logic [7:0]  fout2;
  logic [0:0]  oc2;
  logic [3:0]  d2_in [0:2];
  logic [7:0]  d2_out [0:0];

  always_comb begin
    for (int j = 0; j < 4; j++) d0_in[j] = fin0[31-8*j -: 8];
    d1_in[0] = fin1;
    for (int j = 0; j < 3; j++) d2_in[j] = fin2[11-4*j -: 4];
  end

  always_comb begin
    fout0 = '0;
    fout1 = '0;
    for (int j = 0; j < 2; j++) fout0[15-8*j -: 8] = d0_out[j];
    for (int j = 0; j < 3; j++) fout1[23-8*j -: 8] = d1_out[j];
    fout2 = d2_out[0];
  end

  reshape_stream #(.NBIT_I(8), .CNT_I(4), .NBIT_O(8), .CNT_O(2)) u_dut0 (
    .clk(clk), .rst(rst), .i_valid(iv0), .i_ready(ir0), .i_data(d0_in), .i_last(il0),
    .o_valid(ov0), .o_ready(ordy0), .o_data(d0_out), .o_last(ol0), .o_cnt(oc0));

  reshape_stream #(.NBIT_I(8), .CNT_I(1), .NBIT_O(8), .CNT_O(3)) u_dut1 (
    .clk(clk), .rst(rst), .i_valid(iv1), .i_ready(ir1), .i_data(d1_in), .i_last(il1),
    .o_valid(ov1), .o_ready(ordy1), .o_data(d1_out), .o_last(ol1), .o_cnt(oc1));

  reshape_stream #(.NBIT_I(4), .CNT_I(3), .NBIT_O(8), .CNT_O(1)) u_dut2 (
    .clk(clk), .rst(rst), .i_valid(iv2), .i_ready(ir2), .i_data(d2_in), .i_last(il2),
    .o_valid(ov2), .o_ready(ordy2), .o_data(d2_out), .o_last(ol2), .o_cnt(oc2));

  task automatic set_in(input int k, input logic v, input logic [31:0] d,
                        input logic l, input logic r);
    case (k)
      0:       begin iv0 = v; fin0 = d;        il0 = l; ordy0 = r; end
      1:       begin iv1 = v; fin1 = d[7:0];   il1 = l; ordy1 = r; end
      default: begin iv2 = v; fin2 = d[11:0];  il2 = l; ordy2 = r; end
    endcase
  endtask

  task automatic get_out(input int k, output logic ov, output logic ir,
                         output logic [31:0] od, output logic ol, output logic [3:0] oc);
    case (k)
      0:       begin ov = ov0; ir = ir0; od = 32'(fout0); ol = ol0; oc = 4'(oc0); end
      1:       begin ov = ov1; ir = ir1; od = 32'(fout1); ol = ol1; oc = 4'(oc1); end
      default: begin ov = ov2; ir = ir2; od = 32'(fout2); ol = ol2; oc = 4'(oc2); end
    endcase
  endtask

  function automatic exp_t mk_exp(input logic [31:0] d, input logic l, input int c);
    exp_t e;
    e.data = d;
    e.last = l;
    e.cnt  = c;
    return e;
  endfunction

  function automatic in_t mk_in(input logic [31:0] d, input logic l);
    in_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  // Drive in_q into instance k and compare every accepted output beat with
  // exp_q; also checks hold stability under backpressure and that no extra
  // beat appears once the packet is done.
  task automatic run(input int k, input bit rnd, input string tag);
    int          idx = 0;
    int          cyc = 0;
    bit          hold = 0;
    logic        v, r, ov, ir, ol, any_v;
    logic [31:0] od;
    logic [3:0]  oc;
    logic [37:0] cur, prev;
    exp_t        e;
    prev = '0;
    @(posedge clk); #1;
    while ((idx < in_q.size() || exp_q.size() != 0) && cyc < 3000) begin
      v = (idx < in_q.size()) && (!rnd || $urandom_range(0, 3) != 0);
      r = !rnd || $urandom_range(0, 2) != 0;
      set_in(k, v, v ? in_q[idx].data : 32'h0, v ? in_q[idx].last : 1'b0, r);
      @(negedge clk);
      get_out(k, ov, ir, od, ol, oc);
      cur = {ov, od, ol, oc};
      if (hold) begin
        n_checks++;
        if (cur !== prev) begin
          n_fail++;
          $display("FAIL %s hold_stable: got %h required %h", tag, cur, prev);
        end
      end
      if (ov && r) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_beat: got data %h last %b cnt %0d required no beat", tag, od, ol, oc);
        end else begin
          e = exp_q.pop_front();
          if ({od, ol, oc} !== {e.data, e.last, 4'(e.cnt)}) begin
            n_fail++;
            $display("FAIL %s beat: got data %h last %b cnt %0d required data %h last %b cnt %0d",
                     tag, od, ol, oc, e.data, e.last, e.cnt);
          end
        end
      end
      hold = ov && !r;
      prev = cur;
      if (v && ir) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d inputs left %0d beats left required 0 0",
               tag, in_q.size() - idx, exp_q.size());
    end
    set_in(k, 0, 32'h0, 0, 1);
    any_v = 0;
    repeat (3) begin
      @(negedge clk);
      get_out(k, ov, ir, od, ol, oc);
      any_v |= ov;
      @(posedge clk); #1;
    end
    n_checks++;
    if (any_v !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_packet: got o_valid %b required 0", tag, any_v);
    end
    set_in(k, 0, 32'h0, 0, 0);
    in_q.delete();
    exp_q.delete();
  endtask

  // Reference model: concatenate the packet's input bits, then cut them into
  // OW-bit beats, zero-padding the tail and counting its elements.
  task automatic gen_packet(input int k);
    bit          bits [$];
    int          nb, n;
    logic [31:0] d, m;
    exp_t        e;
    nb = $urandom_range(1, 5);
    m  = 32'((64'd1 << IWA[k]) - 64'd1);
    for (int i = 0; i < nb; i++) begin
      d = $urandom & m;
      for (int bi = IWA[k] - 1; bi >= 0; bi--) bits.push_back(d[bi]);
      in_q.push_back(mk_in(d, i == nb - 1));
    end
    while (bits.size() > 0) begin
      n = (bits.size() < OWA[k]) ? bits.size() : OWA[k];
      e.data = '0;
      for (int bi = 0; bi < OWA[k]; bi++)
        e.data = {e.data[30:0], (bi < n) ? bits[bi] : 1'b0};
      e.cnt  = (n + NBOA[k] - 1) / NBOA[k];
      e.last = (bits.size() <= OWA[k]);
      for (int bi = 0; bi < n; bi++) void'(bits.pop_front());
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    logic ov, ir, ol;
    logic [31:0] od;
    logic [3:0] oc;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      get_out(k, ov, ir, od, ol, oc);
      n_checks++;
      if ({ov, ir, od, ol, oc} !== '0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got v%b r%b d%h l%b c%0d required all zero", k, ov, ir, od, ol, oc);
      end
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_downsize();
    logic ov, ir, ol;
    logic [31:0] od;
    logic [3:0] oc;
    logic [38:0] exp_v [3];
    exp_v[0] = {1'b1, 1'b0, 32'h1122, 1'b0, 4'd2};
    exp_v[1] = {1'b1, 1'b0, 32'h3344, 1'b1, 4'd2};
    exp_v[2] = {1'b0, 1'b1, 32'h0000, 1'b0, 4'd0};
    @(posedge clk); #1;
    set_in(0, 1, 32'h11223344, 1, 1);
    @(posedge clk); #1;
    set_in(0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      get_out(0, ov, ir, od, ol, oc);
      n_checks++;
      if ({ov, ir, od, ol, oc} !== exp_v[i]) begin
        n_fail++;
        $display("FAIL downsize step%0d: got v%b r%b d%h l%b c%0d required %h", i, ov, ir, od, ol, oc, exp_v[i]);
      end
      @(posedge clk); #1;
    end
    set_in(0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_upsize();
    in_q.push_back(mk_in(32'h01, 0));
    in_q.push_back(mk_in(32'h02, 0));
    in_q.push_back(mk_in(32'h03, 0));
    in_q.push_back(mk_in(32'h04, 1));
    exp_q.push_back(mk_exp(32'h010203, 0, 3));
    exp_q.push_back(mk_exp(32'h040000, 1, 1));
    run(1, 0, "upsize");
  endtask

  task automatic test_nonintegral();
    in_q.push_back(mk_in(32'hABC, 0));
    in_q.push_back(mk_in(32'hDEF, 1));
    exp_q.push_back(mk_exp(32'hAB, 0, 1));
    exp_q.push_back(mk_exp(32'hCD, 0, 1));
    exp_q.push_back(mk_exp(32'hEF, 1, 1));
    run(2, 0, "nonintegral");
  endtask

  task automatic test_backpressure();
    logic ov, ir, ol;
    logic [31:0] od;
    logic [3:0] oc;
    @(posedge clk); #1;
    set_in(0, 1, 32'hA1B2C3D4, 0, 0);
    @(posedge clk); #1;
    set_in(0, 0, 32'h0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      get_out(0, ov, ir, od, ol, oc);
      n_checks++;
      if ({ov, ir, od, ol, oc} !== {1'b1, 1'b0, 32'hA1B2, 1'b0, 4'd2}) begin
        n_fail++;
        $display("FAIL backpressure_stall: got v%b r%b d%h l%b c%0d required v1 r0 d0000a1b2 l0 c2", ov, ir, od, ol, oc);
      end
      @(posedge clk); #1;
    end
    in_q.push_back(mk_in(32'h55667788, 1));
    exp_q.push_back(mk_exp(32'hA1B2, 0, 2));
    exp_q.push_back(mk_exp(32'hC3D4, 0, 2));
    exp_q.push_back(mk_exp(32'h5566, 0, 2));
    exp_q.push_back(mk_exp(32'h7788, 1, 2));
    run(0, 0, "backpressure_resume");
  endtask

  task automatic test_reset_mid();
    logic ov, ir, ol;
    logic [31:0] od;
    logic [3:0] oc;
    @(posedge clk); #1;
    set_in(0, 1, 32'hDEADBEEF, 1, 0);
    @(posedge clk); #1;
    set_in(0, 0, 32'h0, 0, 1);
    @(posedge clk); #1;
    set_in(0, 0, 32'h0, 0, 0);
    @(negedge clk);
    get_out(0, ov, ir, od, ol, oc);
    n_checks++;
    if ({ov, ir, od, ol, oc} !== {1'b1, 1'b0, 32'hBEEF, 1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got v%b r%b d%h l%b c%0d required v1 r0 d0000beef l1 c2", ov, ir, od, ol, oc);
    end
    rst = 1;
    #1;
    get_out(0, ov, ir, od, ol, oc);
    n_checks++;
    if ({ov, ir, od, ol, oc} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got v%b r%b d%h l%b c%0d required all zero", ov, ir, od, ol, oc);
    end
    @(posedge clk); #1;
    rst = 0;
    in_q.push_back(mk_in(32'h01020304, 1));
    exp_q.push_back(mk_exp(32'h0102, 0, 2));
    exp_q.push_back(mk_exp(32'h0304, 1, 2));
    run(0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 6; p++) gen_packet(k);
      run(k, 1, $sformatf("random%0d", k));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_downsize();
    test_upsize();
    test_nonintegral();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
